echo_fx: RTL and testbench
==========================

Name: echo_fx

Overview:
Stereo feedback-echo effect stage that sits between the codec interface's capture side and its playback side. It consumes each 16-bit left/right sample pair presented with the codec VALID level, mixes in an attenuated copy of the output from DEPTH samples earlier, and drives left_out/right_out back to the codec. Both channels share one single-port synchronous-read delay RAM that holds 2*DEPTH words.

Parameters:
DEPTH, 4096, echo delay in samples per channel; power of 2, minimum 4.
AW, log2(DEPTH), per-channel pointer width (derived; not overridden).

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active high
valid  input  1  codec VALID level; a sample pair is taken on its rising edge
left_in  input  16  signed left sample from codec
right_in  input  16  signed right sample from codec
en  input  1  1 = echo applied; 0 = bypass
fb_shift  input  2  echo gain = 2^-(fb_shift+1), giving 1/2, 1/4, 1/8 or 1/16
left_out  output  16  signed processed left sample, to codec
right_out  output  16  signed processed right sample, to codec
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse when left_out/right_out update
overrun  output  1  sticky; set when a valid rise is dropped while busy

Behaviour:
- Reset and clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: left_out=0, right_out=0, ready=0, done=0, overrun=0, ptr=0, valid_d=0, state=CLEAR, clear counter=0. RAM contents are not reset.
- Rise detection: rise = valid & ~valid_d, where valid_d is valid registered every cycle.
- CLEAR:
  - Writes 0 to RAM address clear counter, one address per cycle, for 2*DEPTH cycles.
  - After the write to address 2*DEPTH-1, the FSM goes to IDLE.
  - Valid rises during CLEAR are ignored and do not set overrun.
- RAM addressing: address = {ch, ptr}, with ch=0 for left and ch=1 for right. Read data appears one cycle after the address.
- FSM: IDLE -> RD_L -> RD_R -> WR_L -> WR_R -> IDLE.
  - IDLE: on rise, latch x_l=left_in and x_r=right_in, issue a read of {0,ptr}, and go to RD_L.
  - RD_L: issue a read of {1,ptr}.
  - RD_R: capture d_l from the RAM.
  - WR_L: capture d_r, and write w_l to {0,ptr}.
  - WR_R: write w_r to {1,ptr}; register left_out and right_out together; pulse done; advance ptr.
- Latency: if the rise is sampled at edge N, outputs, done and ptr update at edge N+4. This is well inside the codec's ~32-clock VALID window.
- Arithmetic, per channel:
  - y = sat16(x + (d >>> (fb_shift+1))), using an arithmetic shift and a 17-bit sum.
  - Saturation clamps to 0x7FFF / 0x8000.
  - en=1: output = y, write w = y.
  - en=0: output = x, write w = 0, so stale echo drains and re-enabling starts clean.
- en and fb_shift are sampled in WR_L/WR_R. Changes apply from the next sample; no glitch mid-pair.
- ptr wrap: ptr increments modulo DEPTH, so DEPTH-1 wraps to 0. The echo period is exactly DEPTH samples.
- Busy overlap: a rise while state != IDLE and != CLEAR is dropped and sets overrun=1. It stays set until rst.
- Rise coinciding with return to IDLE: a rise in the same cycle WR_R completes is dropped, because the FSM is not yet in IDLE.
- Reset mid-operation: rst in any state returns to CLEAR with the reset values above. The partially processed pair is discarded, and outputs read 0 until the first post-clear sample.
- Outputs hold their value between samples.

Test Plan:
1. Clear after reset (DEPTH=8): pulse rst, then count cycles -> ready rises exactly 16 cycles after rst deasserts; left_out=right_out=0; overrun=0 even with valid toggling during clear.
2. Impulse echo (DEPTH=8, en=1, fb_shift=0): left_in=0x4000 on sample 0, then 0 -> left_out 0x4000 at sample 0, 0x2000 at 8, 0x1000 at 16, 0 elsewhere; right_out all 0; done pulses 4 cycles after each valid rise.
3. Saturation (DEPTH=8, fb_shift=0): constant left_in=0x7000 -> left_out 0x7000 for samples 0-7, 0x7FFF from sample 8. Constant right_in=0x9000 -> 0x9000, then 0x8000.
4. Bypass and drain: with echo built up as in test 2, set en=0 for 8 samples, then en=1 with zero input -> outputs equal the inputs while en=0; all outputs 0 after re-enable.
5. Overrun: second valid rise 2 cycles after the first -> overrun=1, only one done pulse, ptr advances by 1; overrun persists until rst.
6. Reset mid-pair: assert rst in state RD_R -> next cycle state=CLEAR, left_out=0, done never pulses for that pair; after clear, an impulse at ptr 0 echoes at sample 8.

Source files
------------

// File: rtl/echo_fx.sv
// echo_fx: stereo feedback echo with one shared single-port delay RAM.
// Ports: clk, rst, valid/left_in/right_in (codec), en, fb_shift,
//   left_out/right_out, ready, done, overrun (sticky).
module echo_fx #(
  parameter int DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [15:0] left_in,
  input  logic [15:0] right_in,
  input  logic        en,
  input  logic [1:0]  fb_shift,
  output logic [15:0] left_out,
  output logic [15:0] right_out,
  output logic        ready,
  output logic        done,
  output logic        overrun
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    CLEAR, IDLE, RD_L, RD_R, WR_L, WR_R
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   clr_q, clr_d;
  logic          valid_d_q;
  logic [15:0]   x_l_q, x_l_d, x_r_q, x_r_d;
  logic [15:0]   d_l_q, d_l_d, d_r_q, d_r_d;
  logic [15:0]   o_l_q, o_l_d;
  logic [15:0]   left_out_q, left_out_d;
  logic [15:0]   right_out_q, right_out_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;
  logic [AW:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   ram_rd_q;
  logic [15:0]   mem [2*DEPTH];
  logic          rise;
  logic [15:0]   y_l, y_r;

  function automatic logic [15:0] mix(
    input logic [15:0] x,
    input logic [15:0] d,
    input logic [1:0]  sh
  );
    logic signed [15:0] e;
    logic [16:0]        s;
    e = $signed(d) >>> ({1'b0, sh} + 3'd1);
    s = {x[15], x} + {e[15], e};
    // Sign bits disagree only on overflow.
    if (s[16] != s[15]) mix = s[16] ? 16'h8000 : 16'h7fff;
    else                mix = s[15:0];
  endfunction

  assign rise = valid & ~valid_d_q;
  assign y_l  = mix(x_l_q, d_l_q, fb_shift);
  assign y_r  = mix(x_r_q, d_r_q, fb_shift);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clr_d       = clr_q;
    x_l_d       = x_l_q;
    x_r_d       = x_r_q;
    d_l_d       = d_l_q;
    d_r_d       = d_r_q;
    o_l_d       = o_l_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    unique case (state_q)
      CLEAR: begin
        addr_d  = clr_q;
        we_d    = 1'b1;
        wdata_d = 16'h0000;
        clr_d   = clr_q + (AW+1)'(1);
        if (&clr_q) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          x_l_d   = left_in;
          x_r_d   = right_in;
          addr_d  = {1'b0, ptr_q};
          state_d = RD_L;
        end
      end
      RD_L: begin
        addr_d  = {1'b1, ptr_q};
        state_d = RD_R;
      end
      RD_R: begin
        d_l_d   = ram_rd_q;
        state_d = WR_L;
      end
      WR_L: begin
        d_r_d   = ram_rd_q;
        o_l_d   = en ? y_l : x_l_q;
        // Bypass writes zero so the loop drains.
        wdata_d = en ? y_l : 16'h0000;
        addr_d  = {1'b0, ptr_q};
        we_d    = 1'b1;
        state_d = WR_R;
      end
      WR_R: begin
        wdata_d     = en ? y_r : 16'h0000;
        addr_d      = {1'b1, ptr_q};
        we_d        = 1'b1;
        left_out_d  = o_l_q;
        right_out_d = en ? y_r : x_r_q;
        done_d      = 1'b1;
        ptr_d       = ptr_q + AW'(1);
        state_d     = IDLE;
      end
      default: state_d = CLEAR;
    endcase
    if (rise && state_q != IDLE && state_q != CLEAR)
      overrun_d = 1'b1;
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      clr_q       <= '0;
      valid_d_q   <= 1'b0;
      x_l_q       <= '0;
      x_r_q       <= '0;
      d_l_q       <= '0;
      d_r_q       <= '0;
      o_l_q       <= '0;
      left_out_q  <= '0;
      right_out_q <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clr_q       <= clr_d;
      valid_d_q   <= valid;
      x_l_q       <= x_l_d;
      x_r_q       <= x_r_d;
      d_l_q       <= d_l_d;
      d_r_q       <= d_r_d;
      o_l_q       <= o_l_d;
      left_out_q  <= left_out_d;
      right_out_q <= right_out_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
    end
  end

  // Address/data are registered, so each access lands one cycle
  // after the state that issues it.
  always_ff @(posedge clk) begin
    if (we_q) mem[addr_q] <= wdata_q;
    ram_rd_q <= mem[addr_q];
  end

  assign left_out  = left_out_q;
  assign right_out = right_out_q;
  assign ready     = ready_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_fx.sv
// tb_echo_fx: directed scoreboard bench for echo_fx (DEPTH=8).
// Expected pairs are queued at issue; a monitor checks on done.
module tb_echo_fx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] left_in = '0;
  logic [15:0] right_in = '0;
  logic        en = 1'b1;
  logic [1:0]  fb_shift = 2'd0;
  logic [15:0] left_out, right_out;
  logic        ready, done, overrun;

  echo_fx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid(valid),
    .left_in(left_in), .right_in(right_in),
    .en(en), .fb_shift(fb_shift),
    .left_out(left_out), .right_out(right_out),
    .ready(ready), .done(done), .overrun(overrun)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          at;
    string       tag;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued pair.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got l=%h r=%h want none",
                 left_out, right_out);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_l"}, {16'h0, left_out}, {16'h0, e.l});
        chk({e.tag, "_r"}, {16'h0, right_out}, {16'h0, e.r});
        chk({e.tag, "_lat"}, cyc, e.at);
      end
    end
  end

  // One pair; rise seen at next edge, done 4 edges later.
  task automatic send(input string tag, input logic [15:0] l,
                      input logic [15:0] r, input logic [15:0] el,
                      input logic [15:0] er);
    exp_t e;
    @(negedge clk);
    left_in  = l;
    right_in = r;
    valid    = 1'b1;
    e.l = el; e.r = er; e.at = cyc + 5; e.tag = tag;
    q.push_back(e);
    repeat (2) @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'h0, ready}, 32'h1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ready_at;
    logic [15:0] l, r, el, er;

    // 1: reset values and clear length
    repeat (3) @(negedge clk);
    chk("rst_left", {16'h0, left_out}, 32'h0);
    chk("rst_right", {16'h0, right_out}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    ready_at = -1;
    for (int i = 1; i <= 40; i++) begin
      valid = (i % 2 == 1);
      @(negedge clk);
      if (ready === 1'b1) begin
        ready_at = i;
        break;
      end
    end
    valid = 1'b0;
    chk("clear_cycles", ready_at, 16);
    chk("clear_ovr", {31'h0, overrun}, 32'h0);
    chk("clear_left", {16'h0, left_out}, 32'h0);

    // 2: impulse echo, gain 1/2
    en = 1'b1;
    fb_shift = 2'd0;
    for (int k = 0; k < 24; k++) begin
      l  = (k == 0) ? 16'h4000 : 16'h0000;
      el = (k == 0) ? 16'h4000 :
           (k == 8) ? 16'h2000 :
           (k == 16) ? 16'h1000 : 16'h0000;
      send("impulse", l, 16'h0000, el, 16'h0000);
    end

    // 4: bypass with pending 0x0800 echo, then drain
    en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      l = 16'(k + 1) << 8;
      r = 16'hf000 - 16'(k);
      send("bypass", l, r, l, r);
    end
    en = 1'b1;
    for (int k = 0; k < 8; k++)
      send("drain", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // 3: saturation both rails
    for (int k = 0; k < 16; k++) begin
      el = (k < 8) ? 16'h7000 : 16'h7fff;
      er = (k < 8) ? 16'h9000 : 16'h8000;
      send("sat", 16'h7000, 16'h9000, el, er);
    end

    // 5: overrun, gain 1/4
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    chk("ovr_pre", {31'h0, overrun}, 32'h0);
    fb_shift = 2'd1;
    begin
      exp_t e;
      @(negedge clk);
      left_in  = 16'h1234;
      right_in = 16'h0567;
      valid    = 1'b1;
      e.l = 16'h1234; e.r = 16'h0567; e.at = cyc + 5; e.tag = "ovr_pair";
      q.push_back(e);
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    for (int k = 1; k < 8; k++)
      send("ovr_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send("ovr_echo", 16'h0000, 16'h0000, 16'h048d, 16'h0159);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);

    // 6: reset while in RD_R
    @(negedge clk);
    left_in  = 16'h5555;
    right_in = 16'h1111;
    valid    = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_left", {16'h0, left_out}, 32'h0);
    chk("mid_right", {16'h0, right_out}, 32'h0);
    chk("mid_ovr", {31'h0, overrun}, 32'h0);
    chk("mid_ready", {31'h0, ready}, 32'h0);
    wait_ready();
    fb_shift = 2'd0;
    send("post_imp", 16'h4000, 16'hc000, 16'h4000, 16'hc000);
    for (int k = 1; k < 8; k++)
      send("post_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send("post_echo", 16'h0000, 16'h0000, 16'h2000, 16'he000);

    repeat (10) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
